// File: rtl/dmem_responder_if.sv
// Load/store request and response channels between the core (master) and the data memory (slave).
// Both channels use a valid/ready handshake.
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_funct3, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_funct3, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Single-outstanding RV32I data-memory target with fixed LATENCY cycles from accept to rsp_valid.
// Response is held in RESP until rsp_ready; no new request is accepted until then.
module dmem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input logic            clk,
  input logic            rst_n,
  dmem_responder_if.slave bus
);

  localparam int          IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [2:0]  funct3_q;
  logic        rdy_q;
  logic        vld_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic [31:0] mem [DEPTH];

  logic        accept;
  logic        finish;
  logic        cur_we;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;
  logic [2:0]  cur_f3;
  logic        size_b;
  logic        size_h;
  logic        size_w;
  logic        acc_err;
  logic [IDX_W-1:0] idx;
  logic [31:0] rd_word;
  logic [31:0] shifted;
  logic [31:0] load_val;
  logic [31:0] rdata_d;
  logic [31:0] wlanes;
  logic [3:0]  wmask;
  logic        wr_en;

  assign accept = (state_q == IDLE) && rdy_q && bus.req_valid;
  assign finish = (LATENCY == 1) ? accept : ((state_q == WAIT) && (cnt_q == 4'd1));

  // With LATENCY=1 the response is formed on the accept edge, so the live inputs are used.
  always_comb begin
    if (state_q == IDLE) begin
      cur_we    = bus.req_we;
      cur_addr  = bus.req_addr;
      cur_wdata = bus.req_wdata;
      cur_f3    = bus.req_funct3;
    end else begin
      cur_we    = we_q;
      cur_addr  = addr_q;
      cur_wdata = wdata_q;
      cur_f3    = funct3_q;
    end
  end

  always_comb begin
    size_b  = (cur_f3 == 3'd0) || (cur_f3 == 3'd4);
    size_h  = (cur_f3 == 3'd1) || (cur_f3 == 3'd5);
    size_w  = (cur_f3 == 3'd2);
    acc_err = !(size_b || size_h || size_w)
            || (size_h && cur_addr[0])
            || (size_w && (cur_addr[1:0] != 2'b00))
            || ({2'b00, cur_addr[31:2]} >= DEPTH_W);
  end

  assign idx     = cur_addr[IDX_W+1:2];
  assign rd_word = mem[idx];
  assign shifted = rd_word >> {cur_addr[1:0], 3'b000};

  always_comb begin
    case (cur_f3)
      3'd0:    load_val = {{24{shifted[7]}}, shifted[7:0]};
      3'd4:    load_val = {24'd0, shifted[7:0]};
      3'd1:    load_val = {{16{shifted[15]}}, shifted[15:0]};
      3'd5:    load_val = {16'd0, shifted[15:0]};
      3'd2:    load_val = rd_word;
      default: load_val = 32'd0;
    endcase
    rdata_d = (cur_we || acc_err) ? 32'd0 : load_val;
  end

  always_comb begin
    wlanes = cur_wdata;
    wmask  = 4'b0000;
    if (size_b) begin
      wlanes = {4{cur_wdata[7:0]}};
      wmask  = 4'b0001 << cur_addr[1:0];
    end else if (size_h) begin
      wlanes = {2{cur_wdata[15:0]}};
      wmask  = cur_addr[1] ? 4'b1100 : 4'b0011;
    end else if (size_w) begin
      wmask  = 4'b1111;
    end
  end

  // Reset forces state_q to IDLE with rdy_q low, so a store still waiting never reaches this write.
  assign wr_en = finish && cur_we && !acc_err;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wmask[b]) mem[idx][b*8 +: 8] <= wlanes[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      we_q     <= 1'b0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      funct3_q <= 3'd0;
      rdy_q    <= 1'b0;
      vld_q    <= 1'b0;
      rdata_q  <= 32'd0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          rdy_q <= 1'b1;
          if (accept) begin
            we_q     <= bus.req_we;
            addr_q   <= bus.req_addr;
            wdata_q  <= bus.req_wdata;
            funct3_q <= bus.req_funct3;
            rdy_q    <= 1'b0;
            if (LATENCY == 1) begin
              state_q <= RESP;
              vld_q   <= 1'b1;
              rdata_q <= rdata_d;
              err_q   <= acc_err;
            end else begin
              state_q <= WAIT;
              cnt_q   <= 4'(LATENCY - 1);
            end
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q <= RESP;
            vld_q   <= 1'b1;
            rdata_q <= rdata_d;
            err_q   <= acc_err;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state_q <= IDLE;
            vld_q   <= 1'b0;
            rdy_q   <= 1'b1;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          vld_q   <= 1'b0;
          rdy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready = rdy_q;
  assign bus.rsp_valid = vld_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

endmodule
